// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and the idle line level.
package uart_pkg;

  localparam int   UART_DW   = 8;
  localparam int   UART_OVS  = 16;
  localparam logic UART_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit. The reset value is a
// parameter so the output can start at the line's idle level.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the async input, then retime once more to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversamples the synchronized line, validates the start bit at
// its midpoint, shifts in DW data bits LSB-first at mid-bit, checks the stop
// bit and emits a one-cycle rx_valid or frame_err strobe.
// Handshake: rx_valid is a one-cycle push-only strobe with no back-pressure;
// data_out is valid in the cycle rx_valid is high and holds until the next
// good frame. frame_err is a one-cycle strobe and never coincides with rx_valid.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DW  = UART_DW,
  parameter int OVS = UART_OVS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_en,
  input  logic          rx_in,
  output logic [DW-1:0] data_out,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DW + 1);

  localparam logic [SW-1:0] SAMP_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

  logic          w_rx_s;
  logic [DW-1:0] w_shift;

  rx_state_t     r_state,     w_state_nxt;
  logic [SW-1:0] r_samp_cnt,  w_samp_nxt;
  logic [BW-1:0] r_bit_cnt,   w_bit_nxt;
  logic [DW-1:0] r_shreg,     w_shreg_nxt;
  logic [DW-1:0] r_data,      w_data_nxt;
  logic          r_rx_valid,  w_valid_nxt;
  logic          r_frame_err, w_ferr_nxt;

  uart_sync2 #(
    .RST_VAL (UART_IDLE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx_in),
    .o_q (w_rx_s)
  );

  // New sample enters at the MSB so the first (LSB) bit ends up in bit 0.
  if (DW == 1) begin : g_shift_one
    assign w_shift = w_rx_s;
  end else begin : g_shift_many
    assign w_shift = {w_rx_s, r_shreg[DW-1:1]};
  end

  // Next-state, counter, shift and strobe decode; only tick cycles advance.
  always_comb begin
    w_state_nxt = r_state;
    w_samp_nxt  = r_samp_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    if (tick_en) begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = START;
            w_samp_nxt  = '0;
            w_bit_nxt   = '0;
          end
        end
        START: begin
          // Half-bit offset here puts every later sample at mid-bit.
          if (r_samp_cnt == SAMP_HALF) begin
            w_samp_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rx_s ? IDLE : DATA;
          end else begin
            w_samp_nxt = r_samp_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_samp_cnt == SAMP_LAST) begin
            w_samp_nxt  = '0;
            w_shreg_nxt = w_shift;
            if (r_bit_cnt == BIT_LAST) begin
              w_bit_nxt   = '0;
              w_state_nxt = STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 1'b1;
            end
          end else begin
            w_samp_nxt = r_samp_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_samp_cnt == SAMP_LAST) begin
            w_samp_nxt = '0;
            w_bit_nxt  = '0;
            if (w_rx_s) begin
              w_data_nxt  = r_shreg;
              w_valid_nxt = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = BREAK;
            end
          end else begin
            w_samp_nxt = r_samp_cnt + 1'b1;
          end
        end
        BREAK: begin
          // Wait out a held-low line so it cannot retrigger a start.
          if (w_rx_s) begin
            w_state_nxt = IDLE;
            w_samp_nxt  = '0;
            w_bit_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_samp_nxt  = '0;
          w_bit_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_samp_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_samp_cnt  <= w_samp_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shreg     <= w_shreg_nxt;
      r_data      <= w_data_nxt;
      r_rx_valid  <= w_valid_nxt;
      r_frame_err <= w_ferr_nxt;
    end
  end

  assign data_out  = r_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames tick-by-tick, records the
// strobes with a negedge monitor and compares against hand-computed values.
module tb_uart_rx;

  localparam int DW  = 8;
  localparam int OVS = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic          clk;
  logic          rst;
  logic          tick_en;
  logic          rx_in;
  logic [DW-1:0] data_out;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;
  logic [2:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  int tick_div   = 1;
  int tick_phase = 0;
  int stall_left = 0;
  int cyc        = 0;

  int valid_cnt, ferr_cnt, both_cnt, busy_cnt;
  int valid_cyc, fall_cyc;

  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  uart_rx #(
    .DW  (DW),
    .OVS (OVS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_en   (tick_en),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Tick generator: one tick every tick_div clocks, suppressed while stalled.
  initial begin
    tick_en = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        stall_left--;
        tick_en = 1'b0;
      end else begin
        tick_phase++;
        if (tick_phase >= tick_div) tick_phase = 0;
        tick_en = (tick_phase == 0);
      end
    end
  end

  // Monitor: records strobes and received bytes.
  initial forever begin
    @(negedge clk);
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      valid_cyc = cyc;
      got_q.push_back(data_out);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick_en !== 1'b1);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_in = b;
    wait_ticks(OVS);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
    @(negedge clk);
    rx_in    = 1'b0;
    fall_cyc = cyc;
    wait_ticks(OVS);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic idle_ticks(input int n);
    @(negedge clk);
    rx_in = 1'b1;
    wait_ticks(n);
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    ferr_cnt  = 0;
    both_cnt  = 0;
    busy_cnt  = 0;
    valid_cyc = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_bytes(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL %s count: got %0d bytes expected %0d", name, got_q.size(), exp_q.size());
      failures++;
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL %s byte%0d: got %h expected %h", name, i, got_q[i], exp_q[i]);
        failures++;
      end
    end
  endtask

  // Scenario tasks.
  task automatic test_reset();
    rx_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (data_out !== 8'h00) begin $display("FAIL reset data_out: got %h expected 00", data_out); failures++; end
    checks++; if (rx_valid !== 1'b0) begin $display("FAIL reset rx_valid: got %b expected 0", rx_valid); failures++; end
    checks++; if (frame_err !== 1'b0) begin $display("FAIL reset frame_err: got %b expected 0", frame_err); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset busy: got %b expected 0", busy); failures++; end
    checks++; if (dbg_state !== ST_IDLE) begin $display("FAIL reset state: got %0d expected %0d", dbg_state, ST_IDLE); failures++; end
    rst = 1'b0;
    idle_ticks(4);
  endtask

  task automatic test_basic();
    tick_div = 1;
    clear_mon();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle_ticks(OVS);
    @(negedge clk);
    checks++; if (valid_cnt !== 1) begin $display("FAIL basic valid_cnt: got %0d expected 1", valid_cnt); failures++; end
    check_bytes("basic");
    checks++; if (ferr_cnt !== 0) begin $display("FAIL basic frame_err: got %0d pulses expected 0", ferr_cnt); failures++; end
    checks++; if (busy_cnt == 0) begin $display("FAIL basic busy_seen: got 0 busy cycles expected >0"); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL basic busy_after: got %b expected 0", busy); failures++; end
    // 2 sync + 1 detect + OVS/2 start + DW*OVS data + OVS stop = 155 clocks.
    checks++; if (valid_cyc - fall_cyc !== 155) begin $display("FAIL basic latency: got %0d expected 155", valid_cyc - fall_cyc); failures++; end
    checks++; if (data_out !== 8'h55) begin $display("FAIL basic data_out: got %h expected 55", data_out); failures++; end
  endtask

  task automatic test_back_to_back();
    tick_div = 3;
    clear_mon();
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    idle_ticks(2 * OVS);
    @(negedge clk);
    checks++; if (valid_cnt !== 2) begin $display("FAIL b2b valid_cnt: got %0d expected 2", valid_cnt); failures++; end
    check_bytes("b2b");
    checks++; if (ferr_cnt !== 0) begin $display("FAIL b2b frame_err: got %0d pulses expected 0", ferr_cnt); failures++; end
    checks++; if (data_out !== 8'h0F) begin $display("FAIL b2b data_out: got %h expected 0f", data_out); failures++; end
    tick_div = 1;
  endtask

  task automatic test_glitch();
    tick_div = 1;
    clear_mon();
    @(negedge clk);
    rx_in = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    rx_in = 1'b1;
    wait_ticks(3 * OVS);
    @(negedge clk);
    checks++; if (busy_cnt == 0) begin $display("FAIL glitch start_entered: got 0 busy cycles expected >0"); failures++; end
    checks++; if (dbg_state !== ST_IDLE) begin $display("FAIL glitch state: got %0d expected %0d", dbg_state, ST_IDLE); failures++; end
    checks++; if (valid_cnt !== 0) begin $display("FAIL glitch rx_valid: got %0d pulses expected 0", valid_cnt); failures++; end
    checks++; if (ferr_cnt !== 0) begin $display("FAIL glitch frame_err: got %0d pulses expected 0", ferr_cnt); failures++; end
    checks++; if (data_out !== 8'h0F) begin $display("FAIL glitch data_out: got %h expected 0f", data_out); failures++; end
  endtask

  task automatic test_frame_err();
    tick_div = 1;
    clear_mon();
    send_frame(8'hC4, 1'b0);
    wait_ticks(3 * OVS);
    @(negedge clk);
    checks++; if (ferr_cnt !== 1) begin $display("FAIL ferr pulses: got %0d expected 1", ferr_cnt); failures++; end
    checks++; if (valid_cnt !== 0) begin $display("FAIL ferr rx_valid: got %0d pulses expected 0", valid_cnt); failures++; end
    checks++; if (both_cnt !== 0) begin $display("FAIL ferr exclusive: got %0d overlaps expected 0", both_cnt); failures++; end
    checks++; if (data_out !== 8'h0F) begin $display("FAIL ferr data_out: got %h expected 0f", data_out); failures++; end
    checks++; if (busy !== 1'b1) begin $display("FAIL ferr busy_held: got %b expected 1", busy); failures++; end
    checks++; if (dbg_state !== ST_BREAK) begin $display("FAIL ferr state: got %0d expected %0d", dbg_state, ST_BREAK); failures++; end
    idle_ticks(OVS);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin $display("FAIL ferr busy_release: got %b expected 0", busy); failures++; end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle_ticks(OVS);
    @(negedge clk);
    checks++; if (valid_cnt !== 1) begin $display("FAIL ferr next_valid: got %0d expected 1", valid_cnt); failures++; end
    check_bytes("ferr_next");
    checks++; if (ferr_cnt !== 1) begin $display("FAIL ferr next_ferr: got %0d expected 1", ferr_cnt); failures++; end
  endtask

  task automatic test_reset_mid();
    tick_div = 1;
    clear_mon();
    @(negedge clk);
    rx_in = 1'b0;
    wait_ticks(OVS);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    rx_in = 1'b1;
    wait_ticks(OVS / 2);
    @(negedge clk);
    checks++; if (dbg_state !== ST_DATA) begin $display("FAIL rstmid pre_state: got %0d expected %0d", dbg_state, ST_DATA); failures++; end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (data_out !== 8'h00) begin $display("FAIL rstmid data_out: got %h expected 00", data_out); failures++; end
    checks++; if (rx_valid !== 1'b0) begin $display("FAIL rstmid rx_valid: got %b expected 0", rx_valid); failures++; end
    checks++; if (frame_err !== 1'b0) begin $display("FAIL rstmid frame_err: got %b expected 0", frame_err); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL rstmid busy: got %b expected 0", busy); failures++; end
    checks++; if (dbg_state !== ST_IDLE) begin $display("FAIL rstmid state: got %0d expected %0d", dbg_state, ST_IDLE); failures++; end
    rst = 1'b0;
    idle_ticks(4 * OVS);
    @(negedge clk);
    checks++; if (valid_cnt !== 0 || ferr_cnt !== 0) begin $display("FAIL rstmid silent: got %0d valid %0d ferr expected 0 0", valid_cnt, ferr_cnt); failures++; end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle_ticks(OVS);
    @(negedge clk);
    checks++; if (valid_cnt !== 1) begin $display("FAIL rstmid next_valid: got %0d expected 1", valid_cnt); failures++; end
    check_bytes("rstmid_next");
  endtask

  task automatic test_stall();
    logic [DW-1:0] d;
    d = 8'h96;
    tick_div = 1;
    clear_mon();
    exp_q.push_back(d);
    @(negedge clk);
    rx_in    = 1'b0;
    fall_cyc = cyc;
    wait_ticks(OVS);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    @(negedge clk);
    rx_in = d[3];
    wait_ticks(OVS / 2);
    stall_left = 50;
    repeat (25) @(posedge clk);
    @(negedge clk);
    checks++; if (dbg_state !== ST_DATA) begin $display("FAIL stall frozen_state: got %0d expected %0d", dbg_state, ST_DATA); failures++; end
    wait_ticks(OVS / 2);
    for (int i = 4; i < DW; i++) send_bit(d[i]);
    send_bit(1'b1);
    idle_ticks(OVS);
    @(negedge clk);
    checks++; if (valid_cnt !== 1) begin $display("FAIL stall valid_cnt: got %0d expected 1", valid_cnt); failures++; end
    check_bytes("stall");
    checks++; if (ferr_cnt !== 0) begin $display("FAIL stall frame_err: got %0d pulses expected 0", ferr_cnt); failures++; end
    checks++; if (valid_cyc - fall_cyc !== 205) begin $display("FAIL stall latency: got %0d expected 205", valid_cyc - fall_cyc); failures++; end
  endtask

  initial begin
    rst   = 1'b1;
    rx_in = 1'b1;
    clear_mon();
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
